// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction prefetcher driving an SRAM-like fetch port into an in-order buffer,
// with redirect/exception flush and discard of responses to stale requests.
module if_prefetch_unit #(
  parameter int WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc0_0000,
  parameter logic [WIDTH-1:0] EXC_PC = 32'hbfc0_0380
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             exc_valid,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  output logic             inst_req,
  output logic             inst_wr,
  output logic [1:0]       inst_size,
  output logic [31:0]      inst_addr,
  output logic [31:0]      inst_wdata,
  input  logic [31:0]      inst_rdata,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] fetch_pc, resp_pc, tgt, redir_pc;
  logic [WIDTH-1:0] pc_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [CW-1:0] inflight, discard, count, inflight_n, discard_n, count_n;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic req, stale, acc, dok, redir, push, pop, req_n;
  assign inst_req = req;
  assign inst_wr = 1'b0;
  assign inst_size = 2'b10;
  assign inst_wdata = '0;
  assign inst_addr = {3'b000, fetch_pc[28:0]};
  assign out_valid = count != '0;
  assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  // resp_pc tracks the PC of the next response that will be kept; stale responses never advance it
  always_comb begin
    acc = req & inst_addr_ok;
    dok = inst_data_ok & (inflight != '0);
    redir = exc_valid | redirect_valid;
    redir_pc = exc_valid ? EXC_PC : redirect_pc;
    push = dok & (discard == '0) & ~redir;
    pop = out_valid & out_ready & ~redir;
    inflight_n = inflight + CW'(acc) - CW'(dok);
    count_n = redir ? '0 : count + CW'(push) - CW'(pop);
    discard_n = redir ? inflight_n : discard - CW'(dok & (discard != '0)) + CW'(acc & stale);
    req_n = (req & ~inst_addr_ok) |
            ((inflight_n < CW'(MAX_OUTSTANDING)) &
             (({1'b0, inflight_n} + {1'b0, count_n}) < (CW+1)'(FIFO_DEPTH)));
  end
  // a redirect that lands on an unaccepted request parks the target in tgt until the handshake completes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      tgt <= RESET_PC;
      req <= 1'b0;
      stale <= 1'b0;
      inflight <= '0;
      discard <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      req <= req_n;
      inflight <= inflight_n;
      discard <= discard_n;
      count <= count_n;
      if (redir) begin
        resp_pc <= redir_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        if (req & ~inst_addr_ok) begin
          stale <= 1'b1;
          tgt <= redir_pc;
        end else begin
          stale <= 1'b0;
          fetch_pc <= redir_pc;
        end
      end else begin
        if (push) begin
          resp_pc <= resp_pc + WIDTH'(4);
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (acc) begin
          fetch_pc <= stale ? tgt : fetch_pc + WIDTH'(4);
          stale <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= resp_pc;
      instr_mem[wr_ptr] <= WIDTH'(inst_rdata);
    end
  end
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: directed bench with an in-order memory responder returning ~addr as instruction.
module tb_if_prefetch_unit;
  logic clk = 1'b0;
  logic resetn, redirect_valid, exc_valid, out_ready, out_valid;
  logic [31:0] redirect_pc, out_pc, out_instr, inst_addr, inst_wdata, inst_rdata;
  logic inst_req, inst_wr, inst_addr_ok, inst_data_ok, aok, dok;
  logic [1:0] inst_size;
  logic [31:0] aq [16];
  logic [3:0] hd, tl;
  logic [31:0] acc_q[$], pc_q[$], ins_q[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  if_prefetch_unit dut (
    .clk(clk), .resetn(resetn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok)
  );

  assign inst_addr_ok = aok;
  assign inst_data_ok = dok && (hd != tl);
  assign inst_rdata = ~aq[hd];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hd <= '0;
      tl <= '0;
    end else begin
      if (inst_req && inst_addr_ok) begin
        aq[tl] <= inst_addr;
        tl <= tl + 4'd1;
      end
      if (inst_data_ok) hd <= hd + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (inst_req && inst_addr_ok) acc_q.push_back(inst_addr);
      if (out_valid && out_ready) begin
        pc_q.push_back(out_pc);
        ins_q.push_back(out_instr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_i(input logic [31:0] p);
    return ~{3'b000, p[28:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    acc_q.delete();
    pc_q.delete();
    ins_q.delete();
  endtask

  task automatic start(input logic ao, input logic dk, input logic rdy);
    resetn = 1'b0;
    aok = ao;
    dok = dk;
    out_ready = rdy;
    redirect_valid = 1'b0;
    exc_valid = 1'b0;
    cyc(2);
    resetn = 1'b1;
    clr();
  endtask

  initial begin
    resetn = 1'b0;
    aok = 1'b0;
    dok = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    exc_valid = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_inst_req", 32'(inst_req), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("const_wr", 32'(inst_wr), 32'd0);
    check("const_size", 32'(inst_size), 32'd2);
    check("const_wdata", inst_wdata, 32'd0);

    start(1'b1, 1'b1, 1'b1);
    cyc(10);
    check("t1_acc0", acc_q[0], 32'h1fc00000);
    check("t1_acc1", acc_q[1], 32'h1fc00004);
    check("t1_pc0", pc_q[0], 32'hbfc00000);
    check("t1_ins0", ins_q[0], exp_i(32'hbfc00000));
    check("t1_pc1", pc_q[1], 32'hbfc00004);
    clr();
    cyc(6);
    check("t1_rate", pc_q.size(), 32'd6);
    check("t1_seq", pc_q[5] - pc_q[0], 32'd20);

    start(1'b1, 1'b1, 1'b0);
    cyc(12);
    check("t2_accepts", acc_q.size(), 32'd4);
    check("t2_req_off", 32'(inst_req), 32'd0);
    check("t2_head", out_pc, 32'hbfc00000);
    out_ready = 1'b1;
    cyc(4);
    for (int i = 0; i < 4; i++) check("t2_pop", pc_q[i], 32'hbfc00000 + 32'(4 * i));
    cyc(8);
    check("t2_resume", 32'(acc_q.size() > 4), 32'd1);

    start(1'b1, 1'b0, 1'b1);
    cyc(6);
    check("t3_accepts", acc_q.size(), 32'd2);
    check("t3_req_off", 32'(inst_req), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000100;
    cyc(1);
    redirect_valid = 1'b0;
    dok = 1'b1;
    cyc(12);
    check("t3_pc0", pc_q[0], 32'h80000100);
    check("t3_pc1", pc_q[1], 32'h80000104);
    check("t3_ins0", ins_q[0], exp_i(32'h80000100));
    check("t3_acc2", acc_q[2], 32'h00000100);

    start(1'b1, 1'b1, 1'b1);
    cyc(6);
    exc_valid = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000200;
    cyc(1);
    exc_valid = 1'b0;
    redirect_valid = 1'b0;
    check("t4_flush", 32'(out_valid), 32'd0);
    clr();
    cyc(10);
    check("t4_acc0", acc_q[0], 32'h1fc00380);
    check("t4_pc0", pc_q[0], 32'hbfc00380);
    check("t4_ins0", ins_q[0], exp_i(32'hbfc00380));

    start(1'b0, 1'b1, 1'b1);
    cyc(1);
    check("t5_req_first", 32'(inst_req), 32'd1);
    check("t5_addr0", inst_addr, 32'h1fc00000);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80000300;
    cyc(1);
    redirect_valid = 1'b0;
    check("t5_hold_req", 32'(inst_req), 32'd1);
    check("t5_hold_addr1", inst_addr, 32'h1fc00000);
    cyc(1);
    check("t5_hold_addr2", inst_addr, 32'h1fc00000);
    aok = 1'b1;
    cyc(12);
    check("t5_acc0", acc_q[0], 32'h1fc00000);
    check("t5_acc1", acc_q[1], 32'h00000300);
    check("t5_pc0", pc_q[0], 32'h80000300);
    check("t5_pc1", pc_q[1], 32'h80000304);

    start(1'b1, 1'b1, 1'b0);
    cyc(4);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_pc", out_pc, 32'd0);
    check("t6_async_req", 32'(inst_req), 32'd0);
    start(1'b1, 1'b1, 1'b1);
    cyc(10);
    check("t6_acc0", acc_q[0], 32'h1fc00000);
    check("t6_pc0", pc_q[0], 32'hbfc00000);
    check("t6_pc1", pc_q[1], 32'hbfc00004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
